// File: rtl/edge_det_pkg.sv
// edge_det_pkg: edge-select mode codes and helpers shared by the edge detector files
package edge_det_pkg;
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic evt_sel(input logic [1:0] mode, input logic rise, input logic fall);
    return mode == EDGE_OFF ? 1'b0 : mode == EDGE_RISE ? rise : mode == EDGE_FALL ? fall : rise | fall;
  endfunction
endpackage

// File: rtl/multi_edge_det_if.sv
// multi_edge_det_if: per-channel inputs and edge/event outputs of multi_edge_det
interface multi_edge_det_if #(parameter int CH = 4);
  logic [CH-1:0]   din;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pos_edge;
  logic [CH-1:0]   neg_edge;
  logic [CH-1:0]   any_edge;
  logic [CH-1:0]   evt;
  logic            irq;
  modport master(output din, edge_mode, clr, input level, pos_edge, neg_edge, any_edge, evt, irq);
  modport slave(input din, edge_mode, clr, output level, pos_edge, neg_edge, any_edge, evt, irq);
endinterface

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel - synchroniser, stable-count glitch filter, registered edge pulses
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_level,
  output logic o_pos,
  output logic o_neg,
  output logic o_any,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);
  localparam int CW = clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level, r_level_d, r_pos, r_neg;
  logic                   w_sync_out, w_diff, w_accept;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_diff     = w_sync_out != r_level;
  assign w_accept   = w_diff && r_cnt == LAST;
  assign o_rise_nxt = ~r_level_d & r_level;
  assign o_fall_nxt = r_level_d & ~r_level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pos     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      r_sync    <= SYNC_STAGES'({r_sync, i_din});
      r_cnt     <= (!w_diff || w_accept) ? '0 : r_cnt + 1'b1;
      r_level   <= w_accept ? w_sync_out : r_level;
      r_level_d <= r_level;
      r_pos     <= o_rise_nxt;
      r_neg     <= o_fall_nxt;
    end
  end

  assign o_level = r_level;
  assign o_pos   = r_pos;
  assign o_neg   = r_neg;
  assign o_any   = r_pos | r_neg;
endmodule

// File: rtl/multi_edge_det.sv
// multi_edge_det: CH-channel filtered edge detector with mode-selected events; EDGE_STICKY_EN adds sticky pending bits behind irq
module multi_edge_det
  import edge_det_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input logic            clk,
  input logic            rst_n,
  multi_edge_det_if.slave bus
);
  logic [CH-1:0] w_level, w_pos, w_neg, w_any, w_rise, w_fall, w_evt_nxt;
  logic [CH-1:0] r_evt;
  logic          r_irq, w_irq_nxt;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    edge_det_chan #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_din      (bus.din[i]),
      .o_level    (w_level[i]),
      .o_pos      (w_pos[i]),
      .o_neg      (w_neg[i]),
      .o_any      (w_any[i]),
      .o_rise_nxt (w_rise[i]),
      .o_fall_nxt (w_fall[i])
    );
    // mode is applied to the pre-register edge so evt lines up with pos/neg
    assign w_evt_nxt[i] = evt_sel(bus.edge_mode[2*i +: 2], w_rise[i], w_fall[i]);
  end

`ifdef EDGE_STICKY_EN
  logic [CH-1:0] r_pend;
  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= '0;
    else r_pend <= r_evt | (r_pend & ~bus.clr);
  end
  assign w_irq_nxt = |r_pend;
`else
  assign w_irq_nxt = |r_evt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_evt <= w_evt_nxt;
      r_irq <= w_irq_nxt;
    end
  end

  assign bus.level    = w_level;
  assign bus.pos_edge = w_pos;
  assign bus.neg_edge = w_neg;
  assign bus.any_edge = w_any;
  assign bus.evt      = r_evt;
  assign bus.irq      = r_irq;
endmodule

// File: tb/tb_multi_edge_det.sv
// tb_multi_edge_det: directed stimulus with a scoreboard queue checked by an output monitor
module tb_multi_edge_det;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    int         c;
    logic [3:0] lvl, pos, neg, any, evt;
    logic       irq;
  } exp_t;
  exp_t q[$];

  multi_edge_det_if #(.CH(4)) bus();
  multi_edge_det #(.CH(4), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] l, p, ng, a, e, input logic i);
    exp_t x;
    x.c = c; x.lvl = l; x.pos = p; x.neg = ng; x.any = a; x.evt = e; x.irq = i;
    q.push_back(x);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_level"}, 32'(bus.level), 0);
    chk({nm, "_pos"}, 32'(bus.pos_edge), 0);
    chk({nm, "_neg"}, 32'(bus.neg_edge), 0);
    chk({nm, "_any"}, 32'(bus.any_edge), 0);
    chk({nm, "_evt"}, 32'(bus.evt), 0);
    chk({nm, "_irq"}, 32'(bus.irq), 0);
  endtask

  // any output activity must match the next expected entry, including its cycle
  always @(negedge clk) begin
    exp_t e;
    if ((bus.pos_edge | bus.neg_edge | bus.any_edge | bus.evt) != 0 || bus.irq) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected output at cyc %0d: pos %b neg %b any %b evt %b irq %b, required none",
                 cyc, bus.pos_edge, bus.neg_edge, bus.any_edge, bus.evt, bus.irq);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.lvl !== bus.level || e.pos !== bus.pos_edge || e.neg !== bus.neg_edge ||
            e.any !== bus.any_edge || e.evt !== bus.evt || e.irq !== bus.irq) begin
          n_fail++;
          $display("FAIL scoreboard: got cyc %0d lvl %b pos %b neg %b any %b evt %b irq %b; expected cyc %0d lvl %b pos %b neg %b any %b evt %b irq %b",
                   cyc, bus.level, bus.pos_edge, bus.neg_edge, bus.any_edge, bus.evt, bus.irq,
                   e.c, e.lvl, e.pos, e.neg, e.any, e.evt, e.irq);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    bus.din = '0;
    bus.edge_mode = '0;
    bus.clr = '0;
    step(3);
    chk_idle("reset");
    rst_n = 1'b1;
    step(2);
    // ch0 rise with mode 01, then fall (not selected)
    bus.edge_mode = 8'b00_00_00_01;
    bus.din[0] = 1'b1;
    c = cyc;
    push(c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    push(c + 8, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(5);
    chk("level0_before", 32'(bus.level[0]), 0);
    step(1);
    chk("level0_after", 32'(bus.level[0]), 1);
    step(6);
    bus.din[0] = 1'b0;
    c = cyc;
    push(c + 7, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(12);
    // ch1 3-cycle glitch is rejected, 4-cycle pulse is accepted
    bus.edge_mode = '0;
    bus.din[1] = 1'b1;
    step(3);
    bus.din[1] = 1'b0;
    step(4);
    chk("glitch_level1", 32'(bus.level[1]), 0);
    step(7);
    bus.din[1] = 1'b1;
    c = cyc;
    step(4);
    bus.din[1] = 1'b0;
    push(c + 7, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    push(c + 11, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    step(14);
    // all channels toggle with modes {both, fall, rise, off}
    bus.edge_mode = 8'b11_10_01_00;
    bus.din = 4'hF;
    c = cyc;
    push(c + 7, 4'hF, 4'hF, 4'h0, 4'hF, 4'b1010, 1'b0);
    push(c + 8, 4'hF, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b1);
    step(10);
    bus.din = 4'h0;
    c = cyc;
    push(c + 7, 4'h0, 4'h0, 4'hF, 4'hF, 4'b1100, 1'b0);
    push(c + 8, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b1);
    step(12);
    // reset mid-filter discards the partial count
    bus.edge_mode = 8'b00_00_00_01;
    bus.din[0] = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk_idle("midreset");
    rst_n = 1'b1;
    c = cyc;
    push(c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    push(c + 8, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(12);
    // two edges 8 cycles apart give two irq pulses; clr has no effect
    bus.edge_mode = 8'b00_00_00_11;
    bus.clr = 4'hF;
    bus.din[0] = 1'b0;
    c = cyc;
    push(c + 7, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b0);
    push(c + 8, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(8);
    bus.din[0] = 1'b1;
    c = cyc;
    push(c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    push(c + 8, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    step(12);
    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_edge_det.md
Name: multi_edge_det

Overview:
Parametrised multi-channel edge detector. It replaces the single-bit two-flop edge detector used on video sync and strobe lines. Each channel has:
- a configurable synchroniser,
- a stable-count glitch filter,
- registered rise/fall/any pulses,
- a per-channel edge-select mode.

It sits between asynchronous or sync-domain control inputs (vs/hs/de, buttons, external strobes) and the timing/control FSMs.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser depth per channel (>=1)
FILTER_LEN, 4, consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering beyond one register)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset; all state cleared on a rising clk edge while low
din  input  CH  raw channel inputs, asynchronous to clk
edge_mode  input  2*CH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  input  CH  per-channel pending clear (sticky build only; ignored otherwise)
level  output  CH  filtered, synchronised level
pos_edge  output  CH  1-cycle pulse on filtered 0->1
neg_edge  output  CH  1-cycle pulse on filtered 1->0
any_edge  output  CH  pos_edge | neg_edge
evt  output  CH  1-cycle pulse of edges selected by edge_mode
irq  output  1  OR-reduction of events (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - synchroniser flops, filter counters, level, pos_edge, neg_edge, any_edge, evt, pending and irq all become 0.
  - Reset asserted mid-filter discards any partial count.
- Synchroniser: shift chain of SYNC_STAGES flops per channel; sync_out = last stage.
- Filter, per channel:
  - counter width clog2(FILTER_LEN+1).
  - If sync_out == level: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: level <= sync_out, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse shorter than FILTER_LEN cycles at sync_out never changes level.
- Edge outputs are registered from level and its 1-cycle delayed copy:
  - pos_edge = ~level_d & level;
  - neg_edge = level_d & ~level;
  - each output is high for exactly one cycle per accepted transition.
- Latency: with edge 1 being the first rising edge that samples a new stable din level, pos_edge/neg_edge are high after edge SYNC_STAGES+FILTER_LEN+1. With defaults this is edge 7.
- Since level resets to 0, a din held high through reset produces one pos_edge SYNC_STAGES+FILTER_LEN+1 cycles after rst_n deasserts. This is required behaviour.
- evt[i] is registered alongside the edge outputs (same cycle as pos_edge/neg_edge) and is selected by edge_mode:
  - 00: 0
  - 01: pos_edge
  - 10: neg_edge
  - 11: any_edge
- edge_mode is sampled combinationally with the edge; a mode change takes effect for edges occurring in that same cycle.
- Channels are fully independent; simultaneous edges on several channels are all reported.
- Minimum spacing between two reported edges on one channel is FILTER_LEN cycles.

Optional Feature:
Macro EDGE_STICKY_EN.
- Defined:
  - per-channel pend register; set when evt[i]=1, cleared when clr[i]=1 and evt[i]=0.
  - Simultaneous set and clear: set wins, so pend stays 1.
  - irq = |pend, registered, rising one cycle after pend sets.
- Undefined:
  - no pend storage; clr is ignored.
  - irq = |evt, registered, i.e. a 1-cycle pulse one cycle after evt.

Decomposition:
- Package edge_det_pkg holds:
  - mode localparams EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11;
  - a clog2 function for the counter width.
- Sub-module edge_det_chan: one channel (synchroniser, filter, level_d, pos/neg/any). multi_edge_det instantiates CH copies via generate and adds the evt mux, pend and irq.

Test Plan:
- Defaults, din[0] 0->1 held, mode 01 -> pos_edge[0]=evt[0]=1 for one cycle at edge 7; level[0]=1 from edge 6; neg_edge stays 0.
- din[1] high pulse of 3 cycles, FILTER_LEN=4 -> level[1], pos_edge[1] and neg_edge[1] remain 0. A 4-cycle pulse instead -> one pos_edge, then one neg_edge exactly 4 cycles later.
- edge_mode = {11,10,01,00}, all four channels toggled together:
  - ch0 evt never fires;
  - ch1 evt on rise only;
  - ch2 evt on fall only;
  - ch3 evt on both;
  - any_edge fires on every channel.
- EDGE_STICKY_EN: edge on ch2 -> pend[2]=1 and irq=1 the following cycle. clr[2] asserted in the same cycle as a new evt[2] -> pend[2] stays 1. clr[2] alone -> irq drops one cycle later.
- rst_n pulled low for one cycle mid-filter (cnt=2) -> all outputs 0 next cycle; with din held high, pos_edge fires 7 cycles after rst_n returns high.
- Without EDGE_STICKY_EN: two edges on ch0 8 cycles apart -> two separate 1-cycle irq pulses; clr has no effect.
